// File: rtl/if_id_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg_pkg
//   Shared definitions for the IF/ID pipeline register and its skid buffer:
//   default path widths, the NOP instruction, the packed IF/ID entry layout,
//   the skid-buffer state encoding and a helper that turns that state into an
//   entry count.
// -----------------------------------------------------------------------------
package if_id_pipe_reg_pkg;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 16;

  // MIPS "sll $0,$0,0" encodes as all zeros and is the canonical bubble.
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // One IF/ID entry: PC+4 in the upper bits, instruction in the lower bits.
  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } if_id_entry_t;

  // Skid buffer fill level. The skid slot is only ever used while the main
  // slot is occupied, so "skid full, main empty" is not representable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occupancy_of(input skid_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      SKID_ONE:  n = 2'd1;
      SKID_FULL: n = 2'd2;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg_if
//   Bundle of all handshake/data signals between the IF stage, the IF/ID
//   pipeline register and the ID stage.
//
//   Handshake rules (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both 1. A producer holding valid=1 keeps its
//   data stable until the transfer. in_ready is a registered output and never
//   depends combinationally on out_ready.
//
//   Signals:
//     in_valid / in_ready / PCAddResult / Instruction : IF -> pipe register
//     Flush                                           : redirect, drop all
//     out_valid / out_ready / ID_PCAddResult / ID_Instruction : pipe -> ID
//     occupancy   : entries held (0..2)
//     stall_count : saturating count of cycles with out_valid & ~out_ready
//
//   Modports: slave = the pipeline register, master = the surrounding stages.
// -----------------------------------------------------------------------------
interface if_id_pipe_reg_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    PCAddResult;
  logic [INSTR_W-1:0] Instruction;
  logic               Flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    ID_PCAddResult;
  logic [INSTR_W-1:0] ID_Instruction;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   stall_count;

  modport slave (
    input  in_valid, PCAddResult, Instruction, Flush, out_ready,
    output in_ready, out_valid, ID_PCAddResult, ID_Instruction,
           occupancy, stall_count
  );

  modport master (
    output in_valid, PCAddResult, Instruction, Flush, out_ready,
    input  in_ready, out_valid, ID_PCAddResult, ID_Instruction,
           occupancy, stall_count
  );

endinterface

// File: rtl/if_id_pipe_reg_skid_buffer.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer
//   Generic 2-entry valid/ready skid buffer over a DATA_W bus. The main slot
//   drives out_data; the skid slot catches one entry when the consumer stalls,
//   which lets in_ready be a register.
//
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     flush           : synchronous discard of both slots and of the input
//     in_valid/in_ready/in_data    : upstream handshake (in_ready registered)
//     out_valid/out_ready/out_data : downstream handshake (all registered)
//     state           : current fill state, for occupancy and debug
//
//   out_data is cleared to zero by reset/flush and simply held when the main
//   slot drains, so the wrapper decides what a bubble looks like.
// -----------------------------------------------------------------------------
module pipe_skid_buffer
  import if_id_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output skid_state_e       state
);

  logic [DATA_W-1:0] skid_data;
  logic              accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= SKID_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      unique case (state)
        SKID_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (out_ready) begin
            if (accept) begin
              out_data <= in_data;
            end else begin
              // Drained: out_data keeps its last value.
              out_valid <= 1'b0;
              state     <= SKID_EMPTY;
            end
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= SKID_FULL;
          end
        end
        SKID_FULL: begin
          // in_ready is 0 in this state, so no new entry can arrive here;
          // a consume just promotes the skid entry.
          if (out_ready) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          state     <= SKID_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//   IF/ID pipeline register with valid/ready handshakes, a 2-entry skid,
//   synchronous flush, NOP substitution on bubbles and a saturating stall
//   counter.
//
//   Ports:
//     Clk   : rising-edge clock
//     Reset : synchronous, active-high; has priority over Flush
//     bus   : if_id_pipe_reg_if.slave (see interface for signal list)
//
//   When no valid entry is presented ID_Instruction shows NOP_INSTR while
//   ID_PCAddResult keeps the last value (or 0 after reset/flush).
// -----------------------------------------------------------------------------
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int                 PC_W      = DEF_PC_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input logic              Clk,
  input logic              Reset,
  if_id_pipe_reg_if.slave  bus
);

  localparam int DATA_W = PC_W + INSTR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic              skid_in_ready;
  logic [DATA_W-1:0] main_data;
  skid_state_e       skid_state;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_skid_buffer #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (Clk),
    .rst       (Reset),
    .flush     (bus.Flush),
    .in_valid  (bus.in_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({bus.PCAddResult, bus.Instruction}),
    .out_valid (main_valid),
    .out_ready (bus.out_ready),
    .out_data  (main_data),
    .state     (skid_state)
  );

  assign bus.in_ready       = skid_in_ready;
  assign bus.out_valid      = main_valid;
  assign bus.ID_PCAddResult = main_data[DATA_W-1:INSTR_W];
  // The held instruction stays in the register after a drain; mask it so ID
  // only ever sees a real entry or a NOP.
  assign bus.ID_Instruction = main_valid ? main_data[INSTR_W-1:0] : NOP_INSTR;
  assign bus.occupancy      = occupancy_of(skid_state);
  assign bus.stall_count    = stall_cnt;

  // Counts ID back-pressure cycles; Flush deliberately does not clear it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !bus.out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe_reg
//   Directed bench for if_id_pipe_reg (CNT_W = 4). A queue model of the
//   register runs alongside the DUT and every output is compared on each
//   falling edge; hand-computed literals pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_if_id_pipe_reg;
  import if_id_pipe_reg_pkg::*;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam int ENTRY_W = PC_W + INSTR_W;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  if_id_pipe_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change just after a falling edge and are held across one rising edge.
  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl, input logic ordy);
    rst             = r;
    bus.in_valid    = v;
    bus.PCAddResult = pc;
    bus.Instruction = ins;
    bus.Flush       = fl;
    bus.out_ready   = ordy;
    @(negedge clk);
  endtask

  // ---------------- model / scoreboard ----------------
  // The register is a FIFO of at most two entries: it accepts while it holds
  // fewer than two, presents its head, and flush/reset empty it.
  logic [ENTRY_W-1:0] exp_q[$];
  logic [PC_W-1:0]    m_pc    = '0;
  int                 m_stall = 0;
  bit                 m_acc, m_con;
  if_id_entry_t       head;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pc    = '0;
      m_stall = 0;
    end else begin
      m_con = (exp_q.size() > 0) && bus.out_ready;
      m_acc = bus.in_valid && (exp_q.size() < 2);
      if (exp_q.size() > 0 && !bus.out_ready && m_stall < STALL_MAX) m_stall++;
      if (bus.Flush) begin
        exp_q.delete();
        m_pc = '0;
      end else begin
        if (m_con) void'(exp_q.pop_front());
        if (m_acc) exp_q.push_back({bus.PCAddResult, bus.Instruction});
        if (exp_q.size() > 0) begin
          head = if_id_entry_t'(exp_q[0]);
          m_pc = head.pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      head = if_id_entry_t'(exp_q.size() > 0 ? exp_q[0] : '0);
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
      check("ID_Instruction", 64'(bus.ID_Instruction),
            64'(exp_q.size() > 0 ? head.instr : NOP));
      check("ID_PCAddResult", 64'(bus.ID_PCAddResult), 64'(m_pc));
      check("stall_count", 64'(bus.stall_count), 64'(m_stall));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.PCAddResult = '0;
    bus.Instruction = '0; bus.Flush = 1'b0; bus.out_ready = 1'b0;

    // Reset for two cycles
    drive(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst ID_Instruction", 64'(bus.ID_Instruction), 64'd0);
    check("rst ID_PCAddResult", 64'(bus.ID_PCAddResult), 64'd0);
    check("rst stall_count", 64'(bus.stall_count), 64'd0);
    check("rst occupancy", 64'(bus.occupancy), 64'd0);

    // Streaming at one entry per cycle, each visible one cycle after accept
    drive(0, 1, 4, 32'h2008_0001, 0, 1);
    check("stream0 instr", 64'(bus.ID_Instruction), 64'h2008_0001);
    check("stream0 pc", 64'(bus.ID_PCAddResult), 64'd4);
    drive(0, 1, 8, 32'h2009_0002, 0, 1);
    check("stream1 instr", 64'(bus.ID_Instruction), 64'h2009_0002);
    check("stream1 valid", 64'(bus.out_valid), 64'd1);
    drive(0, 1, 12, 32'h012A_4020, 0, 1);
    check("stream2 instr", 64'(bus.ID_Instruction), 64'h012A_4020);
    check("stream2 pc", 64'(bus.ID_PCAddResult), 64'd12);
    drive(0, 0, 0, 0, 0, 1);
    check("bubble valid", 64'(bus.out_valid), 64'd0);
    check("bubble instr", 64'(bus.ID_Instruction), 64'(NOP));
    check("bubble pc held", 64'(bus.ID_PCAddResult), 64'd12);

    // Stall with the skid filling
    drive(0, 1, 4, 32'h2008_0001, 0, 1);
    drive(0, 1, 8, 32'h2009_0002, 0, 0);
    check("stall in_ready", 64'(bus.in_ready), 64'd0);
    drive(0, 1, 12, 32'h012A_4020, 0, 0);
    drive(0, 1, 12, 32'h012A_4020, 0, 0);
    check("stall instr stable", 64'(bus.ID_Instruction), 64'h2008_0001);
    check("stall count 3", 64'(bus.stall_count), 64'd3);
    check("stall occupancy", 64'(bus.occupancy), 64'd2);
    drive(0, 1, 12, 32'h012A_4020, 0, 1);
    check("release1 instr", 64'(bus.ID_Instruction), 64'h2009_0002);
    check("release1 occupancy", 64'(bus.occupancy), 64'd1);
    drive(0, 1, 12, 32'h012A_4020, 0, 1);
    check("release2 instr", 64'(bus.ID_Instruction), 64'h012A_4020);
    drive(0, 0, 0, 0, 0, 1);
    check("release drained", 64'(bus.out_valid), 64'd0);

    // Flush with two entries held and a third offered
    drive(0, 1, 16, 32'hAAAA_0001, 0, 0);
    drive(0, 1, 20, 32'hAAAA_0002, 0, 0);
    check("preflush occupancy", 64'(bus.occupancy), 64'd2);
    drive(0, 1, 24, 32'hAAAA_0003, 1, 0);
    check("flush valid", 64'(bus.out_valid), 64'd0);
    check("flush occupancy", 64'(bus.occupancy), 64'd0);
    check("flush in_ready", 64'(bus.in_ready), 64'd1);
    check("flush instr", 64'(bus.ID_Instruction), 64'd0);
    check("flush pc", 64'(bus.ID_PCAddResult), 64'd0);
    check("flush keeps stall", 64'(bus.stall_count), 64'd5);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("post flush empty", 64'(bus.out_valid), 64'd0);

    // Saturation of the stall counter
    drive(0, 1, 28, 32'hBBBB_0001, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (i == 9) check("stall reaches max", 64'(bus.stall_count), 64'(STALL_MAX));
    end
    check("stall saturated", 64'(bus.stall_count), 64'(STALL_MAX));
    check("sat instr stable", 64'(bus.ID_Instruction), 64'hBBBB_0001);

    // Reset mid-stall with both slots full and Flush also asserted
    drive(0, 1, 32, 32'hBBBB_0002, 0, 0);
    check("prereset occupancy", 64'(bus.occupancy), 64'd2);
    drive(1, 1, 36, 32'hBBBB_0003, 1, 0);
    check("rst2 out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2 in_ready", 64'(bus.in_ready), 64'd1);
    check("rst2 occupancy", 64'(bus.occupancy), 64'd0);
    check("rst2 stall_count", 64'(bus.stall_count), 64'd0);
    check("rst2 instr", 64'(bus.ID_Instruction), 64'd0);

    // Alternating back-pressure after reset; model follows ordering
    drive(0, 1, 40, 32'hCCCC_0001, 0, 1);
    drive(0, 1, 44, 32'hCCCC_0002, 0, 0);
    drive(0, 1, 48, 32'hCCCC_0003, 0, 1);
    drive(0, 1, 48, 32'hCCCC_0003, 0, 1);
    check("alt instr", 64'(bus.ID_Instruction), 64'hCCCC_0003);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
